// File: rtl/kmkz_lsu.sv
// kmkz_lsu: AHB-Lite load/store unit for the Kamikaze-uRV execute stage.
// Stores are posted to a small buffer; loads drain it and then run one transfer at a time.
module kmkz_lsu #(
    parameter int unsigned SBUF_DEPTH = 2,
    parameter logic [31:0] IDLE_HADDR = 32'h8000_0000,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_req_i,
    input  logic        x_kill_i,
    input  logic        x_is_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [31:0] x_addr_i,
    input  logic [31:0] x_wdata_i,
    output logic        x_stall_req_o,
    output logic        x_unaligned_o,
    output logic        w_rd_valid_o,
    output logic [31:0] w_rd_value_o,
    output logic        w_bus_err_o,
    output logic [31:0] w_err_addr_o,
    output logic        sbuf_empty_o,
    output logic [31:0] HADDR,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int PTR_W = (SBUF_DEPTH > 1) ? $clog2(SBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(SBUF_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_ST_A, S_ST_D, S_LD_A, S_LD_D} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_buf_addr [SBUF_DEPTH];
    logic [1:0]         r_buf_size [SBUF_DEPTH];
    logic [31:0]        r_buf_data [SBUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [31:0]        r_xfer_addr;
    logic [1:0]         r_ld_lane;
    logic [2:0]         r_ld_fun;
    logic               r_ld_killed;

    logic               w_misaligned;
    logic               w_full;
    logic               w_st_req;
    logic               w_st_acc;
    logic               w_ld_req;
    logic               w_pop;
    logic               w_ld_done;
    logic [31:0]        w_st_data;
    logic [31:0]        w_head_addr;
    logic [1:0]         w_head_size;
    logic [31:0]        w_shifted;
    logic [31:0]        w_ld_value;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign w_misaligned = ((x_fun_i[1:0] == 2'b01) & x_addr_i[0]) |
                          ((x_fun_i[1:0] == 2'b10) & (|x_addr_i[1:0]));
    assign w_full    = (r_count == CNT_W'(SBUF_DEPTH));
    assign w_st_req  = x_req_i & ~x_is_load_i & ~w_misaligned & ~x_kill_i;
    assign w_st_acc  = w_st_req & ~w_full;
    assign w_ld_req  = x_req_i & x_is_load_i & ~w_misaligned & ~x_kill_i;
    assign w_pop     = (r_state == S_ST_D) & HREADY;
    assign w_ld_done = (r_state == S_LD_D) & HREADY;

    always_comb begin
        w_st_data = x_wdata_i;
        case (x_fun_i[1:0])
            2'b00:   w_st_data = {4{x_wdata_i[7:0]}};
            2'b01:   w_st_data = {2{x_wdata_i[15:0]}};
            default: w_st_data = x_wdata_i;
        endcase
    end

    // An empty buffer lets a freshly accepted store launch in its own accept cycle.
    assign w_head_addr = (r_count != '0) ? r_buf_addr[r_rd_ptr] : x_addr_i;
    assign w_head_size = (r_count != '0) ? r_buf_size[r_rd_ptr] : x_fun_i[1:0];

    assign w_shifted = HRDATA >> {r_ld_lane, 3'b000};
    always_comb begin
        w_ld_value = HRDATA;
        case (r_ld_fun)
            3'b000:  w_ld_value = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ld_value = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ld_value = {24'h0, w_shifted[7:0]};
            3'b101:  w_ld_value = {16'h0, w_shifted[15:0]};
            default: w_ld_value = HRDATA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) || w_st_acc) w_state_nxt = S_ST_A;
                else if (w_ld_req)               w_state_nxt = S_LD_A;
            end
            S_ST_A:  if (HREADY) w_state_nxt = S_ST_D;
            S_ST_D:  if (HREADY) w_state_nxt = S_IDLE;
            S_LD_A:  if (HREADY) w_state_nxt = S_LD_D;
            S_LD_D:  if (HREADY) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        x_unaligned_o = x_req_i & w_misaligned & ~x_kill_i;
        x_stall_req_o = (w_st_req & w_full) |
                        (w_ld_req & ~(w_ld_done & ~r_ld_killed));
        sbuf_empty_o  = (r_count == '0) && (r_state == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(SBUF_DEPTH); i++) begin
                r_buf_addr[i] <= '0;
                r_buf_size[i] <= '0;
                r_buf_data[i] <= '0;
            end
        end else begin
            if (w_st_acc) begin
                r_buf_addr[r_wr_ptr] <= x_addr_i;
                r_buf_size[r_wr_ptr] <= x_fun_i[1:0];
                r_buf_data[r_wr_ptr] <= w_st_data;
                r_wr_ptr             <= ptrInc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptrInc(r_rd_ptr);
            if (w_st_acc && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_st_acc && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Bus registers and write-back pulses; a kill seen during the load transfer is remembered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            HADDR        <= IDLE_HADDR;
            HSIZE        <= 3'b000;
            HTRANS       <= 2'b00;
            HWRITE       <= 1'b0;
            HWDATA       <= 32'h0;
            r_xfer_addr  <= 32'h0;
            r_ld_lane    <= 2'b00;
            r_ld_fun     <= 3'b000;
            r_ld_killed  <= 1'b0;
            w_rd_valid_o <= 1'b0;
            w_rd_value_o <= 32'h0;
            w_bus_err_o  <= 1'b0;
            w_err_addr_o <= 32'h0;
        end else begin
            w_rd_valid_o <= 1'b0;
            w_bus_err_o  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) || w_st_acc) begin
                        HADDR       <= w_head_addr;
                        HSIZE       <= {1'b0, w_head_size};
                        HWRITE      <= 1'b1;
                        HTRANS      <= 2'b10;
                        r_xfer_addr <= w_head_addr;
                    end else if (w_ld_req) begin
                        HADDR       <= x_addr_i;
                        HSIZE       <= {1'b0, x_fun_i[1:0]};
                        HWRITE      <= 1'b0;
                        HTRANS      <= 2'b10;
                        r_xfer_addr <= x_addr_i;
                        r_ld_lane   <= x_addr_i[1:0];
                        r_ld_fun    <= x_fun_i;
                        r_ld_killed <= 1'b0;
                    end
                end
                S_ST_A, S_LD_A: begin
                    if (r_state == S_LD_A && x_kill_i) r_ld_killed <= 1'b1;
                    if (HREADY) begin
                        HTRANS <= 2'b00;
                        HADDR  <= IDLE_HADDR;
                        if (r_state == S_ST_A) HWDATA <= r_buf_data[r_rd_ptr];
                    end
                end
                S_ST_D, S_LD_D: begin
                    if (r_state == S_LD_D && x_kill_i) r_ld_killed <= 1'b1;
                    if (HREADY) begin
                        if (HRESP) begin
                            w_bus_err_o  <= 1'b1;
                            w_err_addr_o <= r_xfer_addr;
                        end else if (r_state == S_LD_D && !r_ld_killed && !x_kill_i) begin
                            w_rd_valid_o <= 1'b1;
                            w_rd_value_o <= w_ld_value;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kmkz_lsu.sv
// Self-checking bench for kmkz_lsu: directed steps plus randomized ops against a transaction-level model.
// A behavioural AHB-Lite slave logs every completed transfer for in-order comparison.
module tb_kmkz_lsu;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] data;
   } xfer_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        xReq, xKill, xIsLoad;
   logic [2:0]  xFun;
   logic [31:0] xAddr, xWdata;
   logic        x_stall_req_o, x_unaligned_o, w_rd_valid_o, w_bus_err_o, sbuf_empty_o;
   logic [31:0] w_rd_value_o, w_err_addr_o;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [1:0]  HTRANS;
   logic        HWRITE, HMASTLOCK, HREADY, HRESP;
   logic [3:0]  HPROT;

   int          checks = 0;
   int          errors = 0;
   xfer_t       busLog[$];
   xfer_t       expQ[$];

   logic        cfgHold = 1'b0;
   logic        cfgErr = 1'b0;
   int          cfgWait = 0;
   int          cfgStWait = 0;
   logic [31:0] cfgRdata = 32'h0;

   logic        slvActive;
   logic        slvErr;
   int          slvWait;
   logic [31:0] slvAddr;
   logic        slvWrite;
   logic [2:0]  slvSize;

   kmkz_lsu dut (
      .clk_i(clock), .rst_i(reset),
      .x_req_i(xReq), .x_kill_i(xKill), .x_is_load_i(xIsLoad), .x_fun_i(xFun),
      .x_addr_i(xAddr), .x_wdata_i(xWdata),
      .x_stall_req_o(x_stall_req_o), .x_unaligned_o(x_unaligned_o),
      .w_rd_valid_o(w_rd_valid_o), .w_rd_value_o(w_rd_value_o),
      .w_bus_err_o(w_bus_err_o), .w_err_addr_o(w_err_addr_o), .sbuf_empty_o(sbuf_empty_o),
      .HADDR(HADDR), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 clock = ~clock;

   // Slave: one data phase at a time, configurable wait states, two-cycle ERROR for reads.
   assign HREADY = !cfgHold && (!slvActive || slvWait == 0);
   assign HRESP  = slvActive && slvErr && slvWait <= 1;
   assign HRDATA = cfgRdata;

   always @(posedge clock) begin
      if (reset) begin
         slvActive <= 1'b0;
         slvErr    <= 1'b0;
         slvWait   <= 0;
      end else if (HREADY) begin
         if (slvActive) busLog.push_back('{addr: slvAddr, write: slvWrite, size: slvSize, data: HWDATA});
         if (HTRANS == 2'b10) begin
            slvActive <= 1'b1;
            slvAddr   <= HADDR;
            slvWrite  <= HWRITE;
            slvSize   <= HSIZE;
            slvErr    <= !HWRITE && cfgErr;
            slvWait   <= HWRITE ? cfgStWait : ((cfgErr && cfgWait < 1) ? 1 : cfgWait);
         end else begin
            slvActive <= 1'b0;
         end
      end else if (slvActive && slvWait > 0) begin
         slvWait <= slvWait - 1;
      end
   end

   // Reference rules: alignment, store lane replication, load lane selection and extension.
   function automatic bit refMisaligned(input logic [2:0] fun, input logic [31:0] a);
      return (fun[1:0] == 2'b01 && a[0]) || (fun[1:0] == 2'b10 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] refStoreData(input logic [2:0] fun, input logic [31:0] rs2);
      logic [31:0] d;
      int bytes;
      bytes = (fun[1:0] == 2'b00) ? 1 : (fun[1:0] == 2'b01) ? 2 : 4;
      d = 32'h0;
      for (int k = 0; k < 4; k++) d = d | (((rs2 >> (8 * (k % bytes))) & 32'hFF) << (8 * k));
      return d;
   endfunction

   function automatic logic [31:0] refLoad(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] word);
      logic [31:0] sh;
      int          v;
      sh = word >> (8 * a[1:0]);
      case (fun)
         3'b000:  begin v = int'(sh & 32'hFF);   if (v >= 128)   v = v - 256;   return 32'(v); end
         3'b001:  begin v = int'(sh & 32'hFFFF); if (v >= 32768) v = v - 65536; return 32'(v); end
         3'b100:  return sh & 32'hFF;
         3'b101:  return sh & 32'hFFFF;
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] alignAddr(input logic [2:0] fun, input logic [31:0] a);
      if (fun[1:0] == 2'b10) return a & ~32'h3;
      if (fun[1:0] == 2'b01) return a & ~32'h1;
      return a;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic req, input logic kill, input logic isLoad,
                                input logic [2:0] fun, input logic [31:0] addr, input logic [31:0] wdata);
      xReq = req; xKill = kill; xIsLoad = isLoad; xFun = fun; xAddr = addr; xWdata = wdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic goIdle();
      applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic doStore(input logic [2:0] fun, input logic [31:0] addr, input logic [31:0] data);
      int n;
      applyStimulus(1'b1, 1'b0, 1'b0, fun, addr, data);
      if (refMisaligned(fun, addr)) begin
         checkOutput("stUnaligned", 32'(x_unaligned_o), 32'd1);
         checkOutput("stUnalignedStall", 32'(x_stall_req_o), 32'd0);
      end else begin
         checkOutput("stAligned", 32'(x_unaligned_o), 32'd0);
         n = 0;
         while (x_stall_req_o && n < 300) begin tick(); n++; end
         checkOutput("stAccept", 32'(x_stall_req_o), 32'd0);
         expQ.push_back('{addr: addr, write: 1'b1, size: {1'b0, fun[1:0]}, data: refStoreData(fun, data)});
      end
      tick();
      goIdle();
   endtask

   task automatic doLoad(input logic [2:0] fun, input logic [31:0] addr, input logic [31:0] rdata,
                         input int waits, input bit err, output int stallCycles, output logic [31:0] value);
      cfgRdata = rdata; cfgWait = waits; cfgErr = err;
      applyStimulus(1'b1, 1'b0, 1'b1, fun, addr, 32'h0);
      expQ.push_back('{addr: addr, write: 1'b0, size: {1'b0, fun[1:0]}, data: 32'h0});
      stallCycles = 0;
      while (x_stall_req_o && stallCycles < 300) begin tick(); stallCycles++; end
      checkOutput("ldStallRelease", 32'(x_stall_req_o), 32'd0);
      tick();
      goIdle();
      value = w_rd_value_o;
      checkOutput("ldValid", 32'(w_rd_valid_o), 32'(!err));
      checkOutput("ldBusErr", 32'(w_bus_err_o), 32'(err));
      if (err) checkOutput("ldErrAddr", w_err_addr_o, addr);
      else     checkOutput("ldValue", w_rd_value_o, refLoad(fun, addr, rdata));
      cfgErr = 1'b0;
   endtask

   task automatic drainCheck();
      int    n;
      xfer_t got, exp;
      n = 0;
      while (!sbuf_empty_o && n < 500) begin tick(); n++; end
      checkOutput("drainEmpty", 32'(sbuf_empty_o), 32'd1);
      checkOutput("busCount", 32'(busLog.size()), 32'(expQ.size()));
      while (busLog.size() > 0 && expQ.size() > 0) begin
         got = busLog.pop_front();
         exp = expQ.pop_front();
         checkOutput("busAddr", got.addr, exp.addr);
         checkOutput("busWrite", 32'(got.write), 32'(exp.write));
         checkOutput("busSize", 32'(got.size), 32'(exp.size));
         if (exp.write) checkOutput("busData", got.data, exp.data);
      end
      busLog.delete();
      expQ.delete();
   endtask

   initial begin
      int          sc, n, kind;
      logic [31:0] v, a;
      logic [2:0]  f;
      bit          sawValid;
      logic [2:0]  loadFuns [5];
      loadFuns = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      reset = 1'b1;
      goIdle();
      repeat (3) tick();
      reset = 1'b0;

      // Reset asserted for two cycles while a store sits in its address phase.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h1000_0000, 32'h1111_1111);
      tick();
      goIdle();
      reset = 1'b1;
      tick();
      tick();
      checkOutput("rstHtrans", 32'(HTRANS), 32'd0);
      checkOutput("rstHaddr", HADDR, 32'h8000_0000);
      checkOutput("rstEmpty", 32'(sbuf_empty_o), 32'd1);
      checkOutput("rstStall", 32'(x_stall_req_o), 32'd0);
      checkOutput("rstRdValid", 32'(w_rd_valid_o), 32'd0);
      checkOutput("rstBusErr", 32'(w_bus_err_o), 32'd0);
      checkOutput("rstErrAddr", w_err_addr_o, 32'd0);
      checkOutput("rstHwdata", HWDATA, 32'd0);
      reset = 1'b0;
      busLog.delete();
      expQ.delete();
      checkOutput("constHburst", 32'(HBURST), 32'd0);
      checkOutput("constHprot", 32'(HPROT), 32'd3);
      checkOutput("constHmastlock", 32'(HMASTLOCK), 32'd0);

      // Single SW with a zero-wait slave.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF);
      checkOutput("swNoStall", 32'(x_stall_req_o), 32'd0);
      expQ.push_back('{addr: 32'h1000_0004, write: 1'b1, size: 3'b010, data: 32'hDEAD_BEEF});
      tick();
      goIdle();
      checkOutput("swHtrans", 32'(HTRANS), 32'd2);
      checkOutput("swHwrite", 32'(HWRITE), 32'd1);
      checkOutput("swHsize", 32'(HSIZE), 32'd2);
      checkOutput("swHaddr", HADDR, 32'h1000_0004);
      tick();
      checkOutput("swHwdata", HWDATA, 32'hDEAD_BEEF);
      checkOutput("swDataPhaseHtrans", 32'(HTRANS), 32'd0);
      drainCheck();

      // Three back-to-back SB with HREADY held low: the third waits for a pop.
      cfgHold = 1'b1;
      for (int i = 0; i < 2; i++) begin
         v = $urandom;
         applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h1000_0100 + 32'(i), v);
         checkOutput("sbNoStall", 32'(x_stall_req_o), 32'd0);
         expQ.push_back('{addr: 32'h1000_0100 + 32'(i), write: 1'b1, size: 3'b000, data: {4{v[7:0]}}});
         tick();
      end
      v = $urandom;
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h1000_0102, v);
      checkOutput("sbFullStall", 32'(x_stall_req_o), 32'd1);
      tick();
      checkOutput("sbFullStallHeld", 32'(x_stall_req_o), 32'd1);
      cfgHold = 1'b0;
      n = 0;
      while (x_stall_req_o && n < 50) begin tick(); n++; end
      checkOutput("sbStallUntilPop", 32'(n), 32'd2);
      expQ.push_back('{addr: 32'h1000_0102, write: 1'b1, size: 3'b000, data: {4{v[7:0]}}});
      tick();
      goIdle();
      drainCheck();

      // LB / LBU lane steering, minimum latency, then a load queued behind two stores.
      doLoad(3'b000, 32'h2000_0003, 32'h8012_3456, 0, 1'b0, sc, v);
      checkOutput("lbValue", v, 32'hFFFF_FF80);
      checkOutput("lbMinStall", 32'(sc), 32'd2);
      doLoad(3'b100, 32'h2000_0003, 32'h8012_3456, 0, 1'b0, sc, v);
      checkOutput("lbuValue", v, 32'h0000_0080);
      cfgStWait = 2;
      doStore(3'b010, 32'h2000_0010, 32'h0102_0304);
      doStore(3'b001, 32'h2000_0016, 32'h0000_A5B6);
      doLoad(3'b101, 32'h2000_0002, 32'hC3D4_1234, 1, 1'b0, sc, v);
      checkOutput("lhuValue", v, 32'h0000_C3D4);
      drainCheck();
      cfgStWait = 0;

      // Misaligned ops are flagged, never stall, never reach the bus.
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b001, 32'h2000_0001, 32'h0);
      checkOutput("lhUnaligned", 32'(x_unaligned_o), 32'd1);
      checkOutput("lhUnalignedStall", 32'(x_stall_req_o), 32'd0);
      tick();
      checkOutput("lhUnalignedHtrans", 32'(HTRANS), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h2000_0002, 32'h1234_5678);
      checkOutput("swUnaligned", 32'(x_unaligned_o), 32'd1);
      checkOutput("swUnalignedStall", 32'(x_stall_req_o), 32'd0);
      tick();
      checkOutput("swUnalignedHtrans", 32'(HTRANS), 32'd0);
      goIdle();
      checkOutput("swUnalignedEmpty", 32'(sbuf_empty_o), 32'd1);

      // Errored LW: error pulse with address, no load result.
      doLoad(3'b010, 32'h3000_0000, $urandom, 1, 1'b1, sc, v);
      tick();
      checkOutput("errPulseEnds", 32'(w_bus_err_o), 32'd0);
      checkOutput("errAddrHeld", w_err_addr_o, 32'h3000_0000);
      drainCheck();

      // Kill while the load is in its data phase: transfer completes, no result.
      cfgWait = 3;
      cfgRdata = 32'h5555_AAAA;
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h4000_0000, 32'h0);
      expQ.push_back('{addr: 32'h4000_0000, write: 1'b0, size: 3'b010, data: 32'h0});
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 32'h4000_0000, 32'h0);
      checkOutput("killNoStall", 32'(x_stall_req_o), 32'd0);
      tick();
      goIdle();
      sawValid = 1'b0;
      n = 0;
      while (!sbuf_empty_o && n < 50) begin
         if (w_rd_valid_o) sawValid = 1'b1;
         tick();
         n++;
      end
      tick();
      checkOutput("killNoValid", 32'(sawValid | w_rd_valid_o), 32'd0);
      drainCheck();
      applyStimulus(1'b1, 1'b1, 1'b1, 3'b010, 32'h4000_0010, 32'h0);
      checkOutput("killPendingNoStall", 32'(x_stall_req_o), 32'd0);
      tick();
      goIdle();
      checkOutput("killPendingNoBus", 32'(HTRANS), 32'd0);

      // Randomized mix of stores, loads (some errored) and misaligned ops.
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         cfgStWait = $urandom_range(0, 2);
         if (kind <= 1) begin
            f = 3'($urandom_range(0, 2));
            doStore(f, alignAddr(f, $urandom), $urandom);
         end else if (kind == 2) begin
            f = loadFuns[$urandom_range(0, 4)];
            doLoad(f, alignAddr(f, $urandom), $urandom, $urandom_range(0, 2),
                   ($urandom_range(0, 7) == 0), sc, v);
         end else begin
            f = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
            a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b01};
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), f, a, $urandom);
            checkOutput("rndUnaligned", 32'(x_unaligned_o), 32'd1);
            checkOutput("rndUnalignedStall", 32'(x_stall_req_o), 32'd0);
            tick();
            goIdle();
         end
      end
      drainCheck();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
